// File: rtl/uart_frame_pkg.sv
// Shared constants and FSM encoding for the UART frame deframer.
package uart_frame_pkg;

    localparam logic [7:0] SYNC1     = 8'h55;
    localparam logic [7:0] SYNC2     = 8'hAA;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC2 = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4
    } state_e;

endpackage

// File: rtl/crc8_d8.sv
// One-byte CRC8 update: MSB-first, no reflection, no final xor.
module crc8_d8
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes 55 AA | LEN | payload | CRC8 byte streams and commits only CRC-clean payloads.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         _MAX_BYTES   = 11,
    parameter int         _TIMEOUT_CYC = 50000,
    parameter logic [7:0] _CRC_POLY    = CRC8_POLY
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [7:0]                uart_data,
    input  logic                      uart_done,
    output logic [8*_MAX_BYTES-1:0]   rev_data,
    output logic [7:0]                pack_num,
    output logic                      pack_ing,
    output logic                      pack_done,
    output logic                      crc_err,
    output logic                      len_err,
    output logic                      timeout_err
);

    localparam int              IW      = (_MAX_BYTES > 1) ? $clog2(_MAX_BYTES) : 1;
    localparam int              TW      = $clog2(_TIMEOUT_CYC + 1);
    localparam logic [7:0]      MAX_LEN = 8'(_MAX_BYTES);
    localparam logic [TW-1:0]   T_LAST  = TW'(_TIMEOUT_CYC - 1);

    state_e                    state_q;
    logic [7:0]                crc_q;
    logic [7:0]                crc_d;
    logic [7:0]                len_q;
    logic [IW-1:0]             idx_q;
    logic [TW-1:0]             tcnt_q;
    logic [7:0]                shadow_q [_MAX_BYTES];
    logic [8*_MAX_BYTES-1:0]   rev_data_q;
    logic [7:0]                pack_num_q;
    logic                      pack_done_q;
    logic                      crc_err_q;
    logic                      len_err_q;
    logic                      timeout_err_q;
    logic                      idx_last;

    crc8_d8 #(.POLY(_CRC_POLY)) u_crc (
        .crc_in  (crc_q),
        .data_in (uart_data),
        .crc_out (crc_d)
    );

    assign idx_last = (8'(idx_q) == (len_q - 8'd1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            crc_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            tcnt_q        <= '0;
            rev_data_q    <= '0;
            pack_num_q    <= '0;
            pack_done_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < _MAX_BYTES; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            pack_done_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;

            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (uart_done) begin
                tcnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (uart_data == SYNC1) state_q <= ST_SYNC2;
                    end
                    ST_SYNC2: begin
                        if (uart_data == SYNC2) begin
                            state_q <= ST_LEN;
                            crc_q   <= CRC8_INIT;
                        end else if (uart_data != SYNC1) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_LEN: begin
                        crc_q <= crc_d;
                        if (uart_data == 8'd0 || uart_data > MAX_LEN) begin
                            state_q   <= ST_IDLE;
                            len_err_q <= 1'b1;
                        end else begin
                            len_q   <= uart_data;
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        shadow_q[idx_q] <= uart_data;
                        crc_q           <= crc_d;
                        idx_q           <= idx_q + 1'b1;
                        if (idx_last) state_q <= ST_CHK;
                    end
                    ST_CHK: begin
                        state_q <= ST_IDLE;
                        if (uart_data == crc_q) begin
                            // Bytes beyond this frame's length keep the last committed value.
                            for (int i = 0; i < _MAX_BYTES; i++) begin
                                if (8'(i) < len_q) rev_data_q[8*i +: 8] <= shadow_q[i];
                            end
                            pack_num_q  <= len_q;
                            pack_done_q <= 1'b1;
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (tcnt_q >= T_LAST) begin
                    state_q       <= ST_IDLE;
                    timeout_err_q <= 1'b1;
                    tcnt_q        <= '0;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
        end
    end

    assign rev_data    = rev_data_q;
    assign pack_num    = pack_num_q;
    assign pack_ing    = (state_q != ST_IDLE);
    assign pack_done   = pack_done_q;
    assign crc_err     = crc_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed-vector bench for uart_frame_parser with hand-computed CRC8 trailers.
module tb_uart_frame_parser;

    localparam int MAXB = 11;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        uart_data = 8'h00;
    logic              uart_done = 1'b0;
    logic [8*MAXB-1:0] rev_data;
    logic [7:0]        pack_num;
    logic              pack_ing;
    logic              pack_done;
    logic              crc_err;
    logic              len_err;
    logic              timeout_err;

    always #5 clk = ~clk;

    uart_frame_parser #(._MAX_BYTES(MAXB), ._TIMEOUT_CYC(TO)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .uart_data   (uart_data),
        .uart_done   (uart_done),
        .rev_data    (rev_data),
        .pack_num    (pack_num),
        .pack_ing    (pack_ing),
        .pack_done   (pack_done),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .timeout_err (timeout_err)
    );

    int n_done = 0, n_crc = 0, n_len = 0, n_to = 0, n_excl = 0;

    always @(negedge clk) begin
        if (pack_done)   n_done++;
        if (crc_err)     n_crc++;
        if (len_err)     n_len++;
        if (timeout_err) n_to++;
        if ((int'(pack_done) + int'(crc_err) + int'(len_err) + int'(timeout_err)) > 1) n_excl++;
    end

    int   tests = 0;
    int   fails = 0;
    logic lat_done;
    int   s_done, s_crc, s_len, s_to, s_excl;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data = b;
        uart_done = 1'b1;
        @(negedge clk);
        lat_done  = pack_done;
        uart_done = 1'b0;
        uart_data = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic snap();
        s_done = n_done; s_crc = n_crc; s_len = n_len; s_to = n_to; s_excl = n_excl;
    endtask

    // Pulse counts since the last snapshot as {done, crc, len, timeout}, one byte each.
    function automatic logic [31:0] ev_counts();
        return {8'(n_done - s_done), 8'(n_crc - s_crc), 8'(n_len - s_len), 8'(n_to - s_to)};
    endfunction

    function automatic logic [31:0] ev_exp(input logic [3:0] e);
        return {7'd0, e[3], 7'd0, e[2], 7'd0, e[1], 7'd0, e[0]};
    endfunction

    typedef struct {
        int           n;
        logic [127:0] bytes;     // first byte sent is the most significant of the n bytes
        logic [3:0]   exp_ev;    // {pack_done, crc_err, len_err, timeout_err}
        logic [7:0]   exp_num;
        logic [87:0]  exp_rev;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5,  128'h55AA010112,                    4'b1000, 8'd1,  88'h01};
        vecs[1] = '{5,  128'h55AA010113,                    4'b0100, 8'd1,  88'h01};
        vecs[2] = '{3,  128'h55AA00,                        4'b0010, 8'd1,  88'h01};
        vecs[3] = '{3,  128'h55AA0C,                        4'b0010, 8'd1,  88'h01};
        vecs[4] = '{8,  128'h00FF5555AA010015,              4'b1000, 8'd1,  88'h00};
        vecs[5] = '{7,  128'h55AA03102030A6,                4'b1000, 8'd3,  88'h302010};
        vecs[6] = '{15, 128'h55AA0B310107020E041C0838107000, 4'b1000, 8'd11, 88'h7010_3808_1C04_0E02_0701_31};
        vecs[7] = '{5,  128'h55AA010112,                    4'b1000, 8'd1,  88'h7010_3808_1C04_0E02_0701_01};
        vecs[8] = '{2,  128'h5512,                          4'b0000, 8'd1,  88'h7010_3808_1C04_0E02_0701_01};

        repeat (3) @(negedge clk);
        check("reset outputs", {rev_data, pack_num, pack_ing, pack_done, crc_err, len_err, timeout_err}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            snap();
            lat_done = 1'b0;
            for (int i = 0; i < vecs[k].n; i++) begin
                send_byte(vecs[k].bytes[8*(vecs[k].n-1-i) +: 8]);
            end
            if (vecs[k].exp_ev[3]) check($sformatf("v%0d pack_done latency", k), lat_done, 1'b1);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d pulses", k), ev_counts(), ev_exp(vecs[k].exp_ev));
            check($sformatf("v%0d pack_num", k), pack_num, vecs[k].exp_num);
            check($sformatf("v%0d rev_data", k), rev_data, vecs[k].exp_rev);
            check($sformatf("v%0d pack_ing", k), pack_ing, 1'b0);
            check($sformatf("v%0d exclusive", k), n_excl - s_excl, 0);
        end

        // Silence after a partial frame: timeout fires on the exact cycle, once.
        snap();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        repeat (TO - 3) @(negedge clk);
        check("to before edge", {pack_ing, timeout_err}, 2'b10);
        @(negedge clk);
        check("to pulse", {pack_ing, timeout_err}, 2'b01);
        repeat (TO + 5) @(negedge clk);
        check("to pulses", ev_counts(), ev_exp(4'b0001));
        check("to rev_data", rev_data, 88'h7010_3808_1C04_0E02_0701_01);

        // A byte landing on the timeout cycle cancels the timeout.
        snap();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        repeat (TO - 3) @(negedge clk);
        send_byte(8'h05);
        check("to cancel state", {pack_ing, timeout_err}, 2'b10);
        lat_done = 1'b0;
        send_byte(8'hD8);
        check("to cancel latency", lat_done, 1'b1);
        repeat (3) @(negedge clk);
        check("to cancel pulses", ev_counts(), ev_exp(4'b1000));
        check("to cancel pack_num", pack_num, 8'd2);
        check("to cancel rev_data", rev_data, 88'h7010_3808_1C04_0E02_0705_01);

        // Reset mid-frame clears everything; a following frame is accepted.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset outputs", {rev_data, pack_num, pack_ing, pack_done, crc_err, len_err, timeout_err}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        snap();
        lat_done = 1'b0;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'h12);
        check("post reset latency", lat_done, 1'b1);
        repeat (3) @(negedge clk);
        check("post reset pulses", ev_counts(), ev_exp(4'b1000));
        check("post reset pack_num", pack_num, 8'd1);
        check("post reset rev_data", rev_data, 88'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
